// File: rtl/sync_fifo_cfg.sv
// Single-clock FIFO with selectable registered-read or first-word-fall-through output,
// registered fill-level flags and sticky overflow/underflow error reporting.
module sync_fifo_cfg #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 16,
   parameter int AEMPTY     = 3,
   parameter int AFULL      = 3,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  wdata_valid,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  write_ack,
   input  logic                  read_req,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  rdata_valid,
   output logic                  fifo_empty,
   output logic                  fifo_aempty,
   output logic                  fifo_full,
   output logic                  fifo_afull,
   output logic [ADDR_WIDTH:0]   fill_level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int LW = ADDR_WIDTH + 1;
   localparam logic [LW-1:0] DEPTH_LVL  = LW'(DEPTH);
   localparam logic [LW-1:0] AEMPTY_LVL = LW'(AEMPTY);
   localparam logic [LW-1:0] AFULL_LVL  = LW'(DEPTH - AFULL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         fill_q, fill_d;
   logic                  empty_q, empty_d, aempty_q, aempty_d;
   logic                  full_q, full_d, afull_q, afull_d;
   logic                  ack_q, ack_d, rvalid_q, rvalid_d;
   logic                  ovf_q, ovf_d, udf_q, udf_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  wr_en, rd_en;

   // Acceptance uses the registered flags, so a full FIFO still pops and an empty one still pushes.
   assign wr_en = wdata_valid & ~full_q & ~flush;
   assign rd_en = read_req & ~empty_q & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      ack_d    = 1'b0;
      rvalid_d = 1'b0;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      rdata_d  = rdata_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d   = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rdata_d  = mem[rd_ptr_q];
         end
         case ({wr_en, rd_en})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
         endcase
         ack_d    = wr_en;
         rvalid_d = rd_en;
         ovf_d    = ovf_q | (wdata_valid & full_q);
         udf_d    = udf_q | (read_req & empty_q);
      end
      empty_d  = (fill_d == '0);
      aempty_d = (fill_d <= AEMPTY_LVL);
      full_d   = (fill_d == DEPTH_LVL);
      afull_d  = (fill_d >= AFULL_LVL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         empty_q  <= 1'b1;
         aempty_q <= 1'b1;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         ack_q    <= 1'b0;
         rvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         empty_q  <= empty_d;
         aempty_q <= aempty_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         ack_q    <= ack_d;
         rvalid_q <= rvalid_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         rdata_q  <= rdata_d;
      end
   end

   // Storage needs no reset; the pointers alone decide which words are live.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= write_data;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign read_data   = empty_q ? '0 : mem[rd_ptr_q];
         assign rdata_valid = ~empty_q;
      end else begin : g_reg
         assign read_data   = rdata_q;
         assign rdata_valid = rvalid_q;
      end
   endgenerate

   assign write_ack   = ack_q;
   assign fifo_empty  = empty_q;
   assign fifo_aempty = aempty_q;
   assign fifo_full   = full_q;
   assign fifo_afull  = afull_q;
   assign fill_level  = fill_q;
   assign overflow    = ovf_q;
   assign underflow   = udf_q;

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Bench for sync_fifo_cfg: one registered-read and one FWFT instance share stimulus;
// a queue scoreboard checks the registered-read data stream.
module tb_sync_fifo_cfg;

   logic        clk = 1'b0;
   logic        reset, flush, wdata_valid, read_req;
   logic [15:0] write_data;

   logic        ack0, rv0, e0, ae0, f0, af0, ov0, un0;
   logic [15:0] rdata0;
   logic [4:0]  lvl0;
   logic        ack1, rv1, e1, ae1, f1, af1, ov1, un1;
   logic [15:0] rdata1;
   logic [4:0]  lvl1;

   int total = 0;
   int bad   = 0;

   int          lvl;
   logic [15:0] mq[$];
   logic [15:0] expq[$];
   bit          ovf_m, udf_m, wacc_m;
   logic [15:0] exp_w;

   always #5 clk = ~clk;

   sync_fifo_cfg #(.FWFT(0)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .wdata_valid(wdata_valid),
      .write_data(write_data), .write_ack(ack0), .read_req(read_req),
      .read_data(rdata0), .rdata_valid(rv0), .fifo_empty(e0), .fifo_aempty(ae0),
      .fifo_full(f0), .fifo_afull(af0), .fill_level(lvl0), .overflow(ov0),
      .underflow(un0));

   sync_fifo_cfg #(.FWFT(1)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .wdata_valid(wdata_valid),
      .write_data(write_data), .write_ack(ack1), .read_req(read_req),
      .read_data(rdata1), .rdata_valid(rv1), .fifo_empty(e1), .fifo_aempty(ae1),
      .fifo_full(f1), .fifo_afull(af1), .fill_level(lvl1), .overflow(ov1),
      .underflow(un1));

   // Every registered-read output word must be the oldest expected pop.
   always @(negedge clk) begin
      if (!reset && rv0 === 1'b1) begin
         total++;
         if (expq.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_extra: got read_data=%h with nothing expected", rdata0);
         end else begin
            exp_w = expq.pop_front();
            if (rdata0 !== exp_w) begin
               bad++;
               $display("[TB] FAIL scoreboard_data: got %h want %h", rdata0, exp_w);
            end
         end
      end
   end

   task automatic drive(input bit fl, input bit wv, input logic [15:0] wd, input bit rr);
      bit racc;
      flush = fl; wdata_valid = wv; write_data = wd; read_req = rr;
      if (fl) begin
         mq.delete(); lvl = 0; ovf_m = 0; udf_m = 0; wacc_m = 0;
      end else begin
         wacc_m = wv && (lvl < 16);
         racc   = rr && (lvl > 0);
         if (wv && lvl == 16) ovf_m = 1;
         if (rr && lvl == 0) udf_m = 1;
         if (racc) begin expq.push_back(mq.pop_front()); lvl--; end
         if (wacc_m) begin mq.push_back(wd); lvl++; end
      end
      @(posedge clk); #1;
      flush = 0; wdata_valid = 0; read_req = 0;
   endtask

   task automatic test_reset();
      reset = 1; flush = 0; wdata_valid = 0; read_req = 0; write_data = '0;
      lvl = 0; ovf_m = 0; udf_m = 0; wacc_m = 0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (lvl0 !== 5'd0 || lvl1 !== 5'd0) begin bad++; $display("[TB] FAIL reset_level: got %0d/%0d want 0", lvl0, lvl1); end
      total++; if ({e0, ae0, f0, af0} !== 4'b1100) begin bad++; $display("[TB] FAIL reset_flags: got %b want 1100", {e0, ae0, f0, af0}); end
      total++; if ({ack0, rv0, ov0, un0, rv1} !== 5'b0) begin bad++; $display("[TB] FAIL reset_ctl: got %b want 00000", {ack0, rv0, ov0, un0, rv1}); end
      total++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin bad++; $display("[TB] FAIL reset_data: got %h/%h want 0000", rdata0, rdata1); end
      reset = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) begin
         drive(0, 1, 16'(i), 0);
         total++; if (ack0 !== 1'b1) begin bad++; $display("[TB] FAIL fill_ack[%0d]: got %b want 1", i, ack0); end
         total++; if (lvl0 !== 5'(i)) begin bad++; $display("[TB] FAIL fill_level[%0d]: got %0d want %0d", i, lvl0, i); end
         total++;
         if ({e0, ae0, f0, af0} !== {1'b0, i <= 3, i == 16, i >= 13}) begin
            bad++; $display("[TB] FAIL fill_flags[%0d]: got %b want %b", i, {e0, ae0, f0, af0}, {1'b0, i <= 3, i == 16, i >= 13});
         end
         total++; if (rdata1 !== 16'h0001 || rv1 !== 1'b1) begin bad++; $display("[TB] FAIL fill_fwft[%0d]: got %h/%b want 0001/1", i, rdata1, rv1); end
      end
   endtask

   task automatic test_overflow();
      drive(0, 1, 16'hBEEF, 0);
      total++; if (ack0 !== 1'b0 || ov0 !== 1'b1 || lvl0 !== 5'd16) begin bad++; $display("[TB] FAIL ovf_write: got ack=%b ovf=%b lvl=%0d want 0/1/16", ack0, ov0, lvl0); end
      drive(0, 0, 0, 0);
      total++; if (ov0 !== 1'b1 || ov1 !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky: got %b/%b want 1", ov0, ov1); end
      for (int i = 1; i <= 16; i++) begin
         drive(0, 0, 0, 1);
         total++; if (lvl0 !== 5'(16 - i)) begin bad++; $display("[TB] FAIL drain_level[%0d]: got %0d want %0d", i, lvl0, 16 - i); end
         if (i < 16) begin
            total++; if (rdata1 !== 16'(i + 1) || rv1 !== 1'b1) begin bad++; $display("[TB] FAIL drain_fwft[%0d]: got %h/%b want %h/1", i, rdata1, rv1, i + 1); end
         end
      end
      total++; if ({e0, ae0, f0, af0, ov0} !== 5'b11001) begin bad++; $display("[TB] FAIL drain_flags: got %b want 11001", {e0, ae0, f0, af0, ov0}); end
      total++; if (rv1 !== 1'b0) begin bad++; $display("[TB] FAIL drain_fwft_valid: got %b want 0", rv1); end
      drive(0, 0, 0, 0);
      total++; if (expq.size() != 0) begin bad++; $display("[TB] FAIL drain_pending: got %0d outstanding want 0", expq.size()); end
   endtask

   task automatic test_underflow();
      drive(0, 0, 0, 1);
      total++; if (un0 !== 1'b1 || rv0 !== 1'b0 || lvl0 !== 5'd0) begin bad++; $display("[TB] FAIL udf_read: got udf=%b valid=%b lvl=%0d want 1/0/0", un0, rv0, lvl0); end
      drive(0, 1, 16'h55AA, 0);
      drive(0, 0, 0, 1);
      total++; if (rv0 !== 1'b1 || rdata0 !== 16'h55AA) begin bad++; $display("[TB] FAIL reg_read: got %h/%b want 55aa/1", rdata0, rv0); end
      drive(0, 0, 0, 0);
      total++; if (rv0 !== 1'b0 || rdata0 !== 16'h55AA || un0 !== 1'b1) begin bad++; $display("[TB] FAIL reg_hold: got %h valid=%b udf=%b want 55aa/0/1", rdata0, rv0, un0); end
   endtask

   task automatic test_fwft();
      drive(1, 0, 0, 0);
      total++; if (un0 !== 1'b0 || ov0 !== 1'b0) begin bad++; $display("[TB] FAIL fwft_flush: got ovf=%b udf=%b want 0/0", ov0, un0); end
      drive(0, 1, 16'h1234, 0);
      total++; if (rdata1 !== 16'h1234 || rv1 !== 1'b1 || rv0 !== 1'b0) begin bad++; $display("[TB] FAIL fwft_show: got %h/%b reg_valid=%b want 1234/1/0", rdata1, rv1, rv0); end
      drive(0, 0, 0, 0);
      total++; if (rdata1 !== 16'h1234 || rv1 !== 1'b1) begin bad++; $display("[TB] FAIL fwft_hold: got %h/%b want 1234/1", rdata1, rv1); end
      drive(0, 0, 0, 1);
      total++; if (rv1 !== 1'b0 || e1 !== 1'b1) begin bad++; $display("[TB] FAIL fwft_pop: got valid=%b empty=%b want 0/1", rv1, e1); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) drive(0, 1, 16'($urandom), 0);
      for (int i = 0; i < 40; i++) begin
         drive(0, 1, 16'($urandom), 1);
         total++; if (lvl0 !== 5'd8 || lvl1 !== 5'd8) begin bad++; $display("[TB] FAIL b2b_level[%0d]: got %0d/%0d want 8", i, lvl0, lvl1); end
         total++; if (rdata1 !== mq[0]) begin bad++; $display("[TB] FAIL b2b_fwft[%0d]: got %h want %h", i, rdata1, mq[0]); end
      end
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      total++; if (expq.size() != 0 || e0 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_drain: got %0d outstanding empty=%b want 0/1", expq.size(), e0); end
   endtask

   task automatic test_flush();
      drive(0, 0, 0, 1);
      for (int i = 0; i < 5; i++) drive(0, 1, 16'h0100 + 16'(i), 0);
      total++; if (lvl0 !== 5'd5 || un0 !== 1'b1) begin bad++; $display("[TB] FAIL flush_pre: got lvl=%0d udf=%b want 5/1", lvl0, un0); end
      drive(1, 1, 16'h0077, 1);
      total++; if (lvl0 !== 5'd0 || e0 !== 1'b1 || ov0 !== 1'b0 || un0 !== 1'b0) begin bad++; $display("[TB] FAIL flush_state: got lvl=%0d empty=%b ovf=%b udf=%b want 0/1/0/0", lvl0, e0, ov0, un0); end
      total++; if (ack0 !== 1'b0 || rv0 !== 1'b0 || rv1 !== 1'b0) begin bad++; $display("[TB] FAIL flush_ctl: got ack=%b valid=%b/%b want 0/0/0", ack0, rv0, rv1); end
      drive(0, 1, 16'hA5A5, 0);
      drive(0, 0, 0, 1);
      total++; if (rdata0 !== 16'hA5A5) begin bad++; $display("[TB] FAIL flush_after: got %h want a5a5", rdata0); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) drive(0, 1, 16'hDD00 + 16'(i), 0);
      @(negedge clk);
      wdata_valid = 1; write_data = 16'hDEAD;
      reset = 1;
      #1;
      total++; if (lvl0 !== 5'd0 || e0 !== 1'b1 || ack0 !== 1'b0 || rv1 !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset: got lvl=%0d empty=%b ack=%b fwft_valid=%b want 0/1/0/0", lvl0, e0, ack0, rv1); end
      mq.delete(); expq.delete(); lvl = 0; ovf_m = 0; udf_m = 0;
      @(posedge clk); #1;
      wdata_valid = 0; reset = 0;
      drive(0, 1, 16'h0F0F, 0);
      total++; if (rdata1 !== 16'h0F0F || lvl0 !== 5'd1) begin bad++; $display("[TB] FAIL mid_after: got %h lvl=%0d want 0f0f/1", rdata1, lvl0); end
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      total++; if (ov0 !== ovf_m || un0 !== udf_m || expq.size() != 0) begin bad++; $display("[TB] FAIL mid_final: got ovf=%b udf=%b pending=%0d want %b/%b/0", ov0, un0, expq.size(), ovf_m, udf_m); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_underflow();
      test_fwft();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
